stream_unpacker: RTL and testbench

Width-converting AXI-stream reader that takes densely packed IN_BYTES-wide words and re-emits them as OUT_BYTES-wide records, flushing a partial tail record on packet end. It sits on the read side of the packed stream, between an upstream FIFO/link and a record consumer. A `pause` input, driven by a downstream FIFO's half-full flag, throttles intake without disturbing records already buffered.

---
 rtl/stream_pkg.sv | 48 ++++
 rtl/keep_to_count.sv | 22 ++
 rtl/stream_unpacker.sv | 167 ++++++++++++++++
 tb/tb_stream_unpacker.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Purpose  : Shared helpers for the packed-stream width converters: count
//            width sizing and conversions between low-contiguous keep masks
//            and byte counts.
// Revision : 1.0 - initial release
// ============================================================================
package stream_pkg;

    // Widest keep mask the helpers handle (64 bytes = 512-bit stream).
    localparam int c_keep_max = 64;

    // Container for keep <-> count conversions; narrower keeps are
    // zero-extended into it.
    typedef logic [c_keep_max-1:0] keep_mask_t;

    // Bits needed to hold a byte count in the range 0..cap.
    function automatic int cnt_width(input int cap);
        return $clog2(cap + 1);
    endfunction

    // Byte count of a low-contiguous keep: index of the highest set bit + 1.
    function automatic int keep_to_bytes(input keep_mask_t keep);
        int n;
        n = 0;
        for (int i = 0; i < c_keep_max; i++) begin
            if (keep[i]) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

    // Low-contiguous keep with the bottom n bits set.
    function automatic keep_mask_t bytes_to_keep(input int n);
        keep_mask_t m;
        m = '0;
        for (int i = 0; i < c_keep_max; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keep_to_count.sv
`default_nettype none
// ============================================================================
// Module   : keep_to_count
// Purpose  : Combinational byte count of a low-contiguous keep mask.
// Ports    : i_keep  [W-1:0]  keep mask, bit 0 = byte 0
//            o_count [CW-1:0] number of kept bytes
// Revision : 1.0 - initial release
// ============================================================================
module keep_to_count
    import stream_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic [W-1:0]  i_keep,
    output logic [CW-1:0] o_count
);

    assign o_count = CW'(keep_to_bytes(keep_mask_t'(i_keep)));

endmodule
`default_nettype wire

// File: rtl/stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : stream_unpacker
// Purpose  : Re-slices densely packed IN_BYTES-wide AXI-stream words into
//            OUT_BYTES-wide records. A residue buffer holds bytes not yet
//            emitted; on tlast the remaining bytes are flushed as a partial
//            tail record with a reduced keep.
// Ports    : clk, rst_n (async, active low)
//            s_axis_* : packed input stream (tdata/tkeep/tlast/tvalid/tready)
//            m_axis_* : record output stream (tdata/tkeep/tlast/tvalid/tready)
//            pause    : blocks new input words while high; buffered records
//                       keep draining
//            rec_count, pkt_count : record / packet counters (optional)
// Options  : UNPACKER_STATS_EN - adds the rec_count/pkt_count ports.
// Revision : 1.0 - initial release
// ============================================================================
module stream_unpacker
    import stream_pkg::*;
#(
    parameter int IN_BYTES  = 8,
    parameter int OUT_BYTES = 3,
    // Derived sizes; leave at their defaults.
    parameter int CAP       = IN_BYTES + OUT_BYTES - 1,
    parameter int CW        = cnt_width(CAP)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*IN_BYTES-1:0]  s_axis_tdata,
    input  logic [IN_BYTES-1:0]    s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic [8*OUT_BYTES-1:0] m_axis_tdata,
    output logic [OUT_BYTES-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   pause
`ifdef UNPACKER_STATS_EN
    ,
    output logic [31:0]            rec_count,
    output logic [31:0]            pkt_count
`endif
);

    localparam int            c_bw      = 8 * CAP;
    localparam logic [CW-1:0] c_in_cnt  = CW'(IN_BYTES);
    localparam logic [CW-1:0] c_out_cnt = CW'(OUT_BYTES);

    logic [c_bw-1:0] r_buf;
    logic [CW-1:0]   r_count;
    logic            r_draining;
    logic            r_ready_en;

    logic            w_s_fire;
    logic            w_m_fire;
    logic            w_tail;
    logic [CW-1:0]   w_keep_cnt;
    logic [CW-1:0]   w_add_cnt;
    logic [c_bw-1:0] w_ins;
    logic [c_bw-1:0] w_ins_mask;
    logic [IN_BYTES:0] w_keep_ext;
    logic            w_keep_legal;

    // Intake only when the buffer cannot yet form a record. This keeps
    // loads and shifts in different cycles and bounds the residue to
    // OUT_BYTES-1 + IN_BYTES = CAP bytes.
    assign s_axis_tready = r_ready_en && !pause && !r_draining && (r_count < c_out_cnt);
    assign m_axis_tvalid = (r_count >= c_out_cnt) || (r_draining && (r_count != '0));
    assign w_tail        = r_draining && (r_count <= c_out_cnt);
    assign w_s_fire      = s_axis_tvalid && s_axis_tready;
    assign w_m_fire      = m_axis_tvalid && m_axis_tready;
    assign m_axis_tdata  = r_buf[8*OUT_BYTES-1:0];

    // Keep/last are gated by valid so they read zero while idle or in reset.
    always_comb begin
        m_axis_tkeep = '0;
        m_axis_tlast = 1'b0;
        if (m_axis_tvalid) begin
            if (w_tail) begin
                m_axis_tkeep = OUT_BYTES'(bytes_to_keep(int'(r_count)));
                m_axis_tlast = 1'b1;
            end else begin
                m_axis_tkeep = '1;
            end
        end
    end

    keep_to_count #(
        .W  (IN_BYTES),
        .CW (CW)
    ) u_keep_cnt (
        .i_keep  (s_axis_tkeep),
        .o_count (w_keep_cnt)
    );

    assign w_add_cnt = s_axis_tlast ? w_keep_cnt : c_in_cnt;

    // Incoming word lands just above the bytes already held.
    assign w_ins      = c_bw'(s_axis_tdata) << {r_count, 3'b000};
    assign w_ins_mask = c_bw'({(8*IN_BYTES){1'b1}}) << {r_count, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_draining <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_s_fire) begin
                r_count <= r_count + w_add_cnt;
                if (s_axis_tlast) begin
                    r_draining <= 1'b1;
                end
            end else if (w_m_fire) begin
                if (w_tail) begin
                    r_count    <= '0;
                    r_draining <= 1'b0;
                end else begin
                    r_count <= r_count - c_out_cnt;
                end
            end
        end
    end

    // Buffer contents are don't-care after reset; only r_count qualifies them.
    always_ff @(posedge clk) begin
        if (w_s_fire) begin
            r_buf <= (r_buf & ~w_ins_mask) | w_ins;
        end else if (w_m_fire) begin
            r_buf <= r_buf >> (8 * OUT_BYTES);
        end
    end

    // A tlast keep must be nonzero and of the form 0..01..1.
    assign w_keep_ext   = {1'b0, s_axis_tkeep};
    assign w_keep_legal = (s_axis_tkeep != '0) &&
                          ((w_keep_ext & (w_keep_ext + 1'b1)) == '0);

    always_ff @(posedge clk) begin
        if (rst_n && w_s_fire && s_axis_tlast) begin
            assert (w_keep_legal);
        end
    end

`ifdef UNPACKER_STATS_EN
    logic [31:0] r_rec_count;
    logic [31:0] r_pkt_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec_count <= '0;
            r_pkt_count <= '0;
        end else if (w_m_fire) begin
            r_rec_count <= r_rec_count + 32'd1;
            if (m_axis_tlast) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign rec_count = r_rec_count;
    assign pkt_count = r_pkt_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_unpacker
// Purpose  : Self-checking bench for stream_unpacker (IN=8, OUT=3). Packets
//            are modelled as byte lists; expected records are queued when a
//            packet is issued and a monitor pops/compares on every m_fire.
// Options  : UNPACKER_STATS_EN - also checks rec_count/pkt_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_unpacker;

    localparam int IN  = 8;
    localparam int OUT = 3;

    typedef logic [7:0] u8_t;
    typedef struct packed {
        logic [8*OUT-1:0] data;
        logic [OUT-1:0]   keep;
        logic             last;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [8*IN-1:0]  s_axis_tdata = '0;
    logic [IN-1:0]    s_axis_tkeep = '0;
    logic             s_axis_tlast = 1'b0;
    logic             s_axis_tvalid = 1'b0;
    logic             s_axis_tready;
    logic [8*OUT-1:0] m_axis_tdata;
    logic [OUT-1:0]   m_axis_tkeep;
    logic             m_axis_tlast;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b0;
    logic             pause = 1'b0;
`ifdef UNPACKER_STATS_EN
    logic [31:0]      rec_count;
    logic [31:0]      pkt_count;
`endif

    stream_unpacker #(
        .IN_BYTES  (IN),
        .OUT_BYTES (OUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .pause         (pause)
`ifdef UNPACKER_STATS_EN
        ,
        .rec_count     (rec_count),
        .pkt_count     (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    rec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 0;     // 0: always ready, 1: 30% random, 2: manual
    logic r_man = 1'b0;
    int   n_rec_seen = 0;
    int   n_pkt_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [8*OUT-1:0] byte_mask(input logic [OUT-1:0] k);
        logic [8*OUT-1:0] m;
        for (int i = 0; i < OUT; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // Reference: a packet of n bytes is cut into ceil(n/OUT) records in
    // byte order; the last one carries tlast and keeps only its real bytes.
    task automatic model_push(input u8_t pkt[$]);
        int n;
        rec_t r;
        n = pkt.size();
        for (int p = 0; p < n; p += OUT) begin
            r = '0;
            for (int b = 0; b < OUT; b++) begin
                if (p + b < n) begin
                    r.data[8*b +: 8] = pkt[p+b];
                    r.keep[b]        = 1'b1;
                end
            end
            r.last = (p + OUT >= n);
            exp_q.push_back(r);
        end
    endtask

    // m_axis_tready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ($urandom_range(0, 9) < 3);
                default: m_axis_tready = r_man;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        rec_t e;
        rec_t held;
        bit   stalled;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled    = 0;
                n_rec_seen = 0;
                n_pkt_seen = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                    check("stall_data", 64'(m_axis_tdata & byte_mask(held.keep)),
                          64'(held.data & byte_mask(held.keep)));
                    check("stall_keep", 64'(m_axis_tkeep), 64'(held.keep));
                    check("stall_last", 64'(m_axis_tlast), 64'(held.last));
                end
                stalled = 0;
                if (m_axis_tvalid && m_axis_tready) begin
                    n_rec_seen++;
                    if (m_axis_tlast) n_pkt_seen++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_record: got data 0x%0h keep %b last %b required none",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast);
                    end else begin
                        e = exp_q.pop_front();
                        check("rec_keep", 64'(m_axis_tkeep), 64'(e.keep));
                        check("rec_last", 64'(m_axis_tlast), 64'(e.last));
                        check("rec_data", 64'(m_axis_tdata & byte_mask(e.keep)),
                              64'(e.data & byte_mask(e.keep)));
                    end
                end else if (m_axis_tvalid) begin
                    stalled = 1;
                    held    = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
                end
            end
        end
    end

    // Called and returns at posedge+1.
    task automatic send_word(input logic [8*IN-1:0] d, input logic [IN-1:0] k,
                             input logic l, input int gap);
        bit done;
        int t;
        s_axis_tvalid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        done = 0;
        t    = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            if (s_axis_tready) done = 1;
            @(posedge clk);
            #1;
            t++;
        end
        s_axis_tvalid = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL input_timeout: got tready 0 for 2000 cycles required 1");
        end
    endtask

    task automatic send_packet(input u8_t pkt[$], input int gap_max, input bit pause_mid);
        int n;
        int nw;
        int fires;
        int gap;
        logic [8*IN-1:0] d;
        logic [IN-1:0]   k;
        n  = pkt.size();
        nw = (n + IN - 1) / IN;
        model_push(pkt);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < IN; b++) begin
                if (w * IN + b < n) begin
                    d[8*b +: 8] = pkt[w*IN+b];
                    k[b]        = 1'b1;
                end else begin
                    d[8*b +: 8] = 8'($urandom);
                    k[b]        = 1'b0;
                end
            end
            gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            send_word(d, k, (w == nw - 1), gap);
            if (pause_mid && w == 0) begin
                pause = 1'b1;
                fires = 0;
                repeat (10) begin
                    @(negedge clk);
                    check("pause_tready", 64'(s_axis_tready), 64'd0);
                    if (m_axis_tvalid && m_axis_tready) fires++;
                end
                check("pause_drain", 64'(fires), 64'd2);
                @(posedge clk);
                #1;
                pause = 1'b0;
            end
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d records outstanding required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: got simulation still running required finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        u8_t pkt[$];
        int  n;

        // Reset state
        #1;
        check("rst_s_tready", 64'(s_axis_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_m_tkeep",  64'(m_axis_tkeep),  64'd0);
        check("rst_m_tlast",  64'(m_axis_tlast),  64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 16 bytes 0x00..0x0F: five full records then a 1-byte tail
        rdy_mode = 0;
        pkt.delete();
        for (int i = 0; i < 16; i++) pkt.push_back(u8_t'(i));
        send_packet(pkt, 0, 0);
        wait_drain();

        // 24 bytes: eight full records, last with tlast
        pkt.delete();
        for (int i = 0; i < 24; i++) pkt.push_back(u8_t'(8'h30 + i));
        send_packet(pkt, 0, 0);
        wait_drain();

        // 10 bytes: 3,3,3 then 1-byte tail
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(u8_t'(8'hA0 + i));
        send_packet(pkt, 0, 0);
        wait_drain();

        // pause held mid-packet
        pkt.delete();
        for (int i = 0; i < 32; i++) pkt.push_back(u8_t'($urandom));
        send_packet(pkt, 0, 1);
        wait_drain();

        // randomized traffic, 30% output ready
        rdy_mode = 1;
        for (int p = 0; p < 1000; p++) begin
            pkt.delete();
            n = int'($urandom_range(1, 30));
            for (int i = 0; i < n; i++) pkt.push_back(u8_t'($urandom));
            send_packet(pkt, 2, 0);
        end
        wait_drain();

`ifdef UNPACKER_STATS_EN
        check("stat_rec", 64'(rec_count), 64'(n_rec_seen));
        check("stat_pkt", 64'(pkt_count), 64'(n_pkt_seen));
`endif

        // reset while draining with 5 bytes held
        rdy_mode = 2;
        r_man    = 1'b0;
        @(posedge clk);
        #1;
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(u8_t'(8'h40 + i));
        send_packet(pkt, 0, 0);
        @(negedge clk);
        r_man = 1'b1;
        @(negedge clk);
        r_man = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 64'(m_axis_tvalid), 64'd1);
        check("pre_rst_keep",  64'(m_axis_tkeep),  64'h7);
        check("pre_rst_last",  64'(m_axis_tlast),  64'd0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_s_tready", 64'(s_axis_tready), 64'd0);
        check("arst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("arst_m_tkeep",  64'(m_axis_tkeep),  64'd0);
        check("arst_m_tlast",  64'(m_axis_tlast),  64'd0);
`ifdef UNPACKER_STATS_EN
        check("arst_rec_count", 64'(rec_count), 64'd0);
        check("arst_pkt_count", 64'(pkt_count), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rdy_mode = 0;
        pkt.delete();
        for (int i = 0; i < 7; i++) pkt.push_back(u8_t'(8'hC0 + i));
        send_packet(pkt, 0, 0);
        wait_drain();
        repeat (10) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
